// File: rtl/pico_dma_master.sv
// ---------------------------------------------------------------------------
// pico_dma_master
//   Word-copy DMA engine acting as an initiator on the PicoRV32 native memory
//   interface. Each word is moved with one read request followed by one write
//   request; requests may be issued back-to-back.
//
// Parameters
//   LEN_W    width of len_words and words_done
//   TIMEOUT  max cycles a request may wait for mem_ready (timeout build only)
//
// Optional feature
//   PICO_DMA_TIMEOUT_EN  when defined, a stalled request is aborted after
//                        TIMEOUT cycles, error is raised and done still pulses.
//                        When undefined, error is tied low and waits are
//                        unbounded.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   start               one-cycle request, sampled only while idle
//   src_addr, dst_addr  byte addresses, low two bits forced to zero
//   len_words           words to copy (0 is legal)
//   busy, done, error   status (done is a one-cycle pulse, error is sticky)
//   words_done          words fully written in the current/last transfer
//   mem_*               PicoRV32 native memory bus, initiator side
// ---------------------------------------------------------------------------
module pico_dma_master #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_STEP = 32'd4;

    // A zero timeout would abort every request before it could complete.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("pico_dma_master: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      src_next;
    logic             handshake;

    assign src_next  = src_ptr + WORD_STEP;
    assign handshake = mem_valid && mem_ready;

`ifdef PICO_DMA_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;

    // Last permitted waiting cycle: the request has then been valid TIMEOUT cycles.
    assign timeout_hit = mem_valid && !mem_ready && (wait_cnt == TO_W'(TIMEOUT - 1));
`else
    assign error = 1'b0;
`endif

    // Transfer FSM; the data register is mem_wdata itself.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
`ifdef PICO_DMA_TIMEOUT_EN
            error      <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PICO_DMA_TIMEOUT_EN
            if (mem_valid && !mem_ready) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr    <= src_addr & ADDR_MASK;
                        dst_ptr    <= dst_addr & ADDR_MASK;
                        remaining  <= len_words;
                        words_done <= '0;
                        busy       <= 1'b1;
`ifdef PICO_DMA_TIMEOUT_EN
                        error      <= 1'b0;
                        wait_cnt   <= '0;
`endif
                        if (len_words != '0) begin
                            state     <= S_RD;
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr & ADDR_MASK;
                            mem_wstrb <= 4'b0000;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    // Read completes: turn straight into the write request.
                    if (handshake) begin
                        state     <= S_WR;
                        mem_wdata <= mem_rdata;
                        mem_addr  <= dst_ptr;
                        mem_wstrb <= 4'b1111;
`ifdef PICO_DMA_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end

                S_WR: begin
                    if (handshake) begin
                        src_ptr    <= src_next;
                        dst_ptr    <= dst_ptr + WORD_STEP;
                        words_done <= words_done + LEN_W'(1);
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining != LEN_W'(1)) begin
                            state     <= S_RD;
                            mem_addr  <= src_next;
                            mem_wstrb <= 4'b0000;
`ifdef PICO_DMA_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end else begin
                            state     <= S_FIN;
                            mem_valid <= 1'b0;
                            mem_wstrb <= 4'b0000;
                            done      <= 1'b1;
                        end
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase

`ifdef PICO_DMA_TIMEOUT_EN
            // Abort a stalled request; overrides the waiting state above.
            if ((state == S_RD || state == S_WR) && timeout_hit) begin
                state     <= S_FIN;
                mem_valid <= 1'b0;
                mem_wstrb <= 4'b0000;
                error     <= 1'b1;
                done      <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/pico_dma_master.md
Name: pico_dma_master

Overview:
- Bus-master (initiator) side of the PicoRV32 native memory interface: mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata.
- Copies a block of 32-bit words from src to dst, one read then one write per word.
- Connects to any existing word-memory/IO responder, either in place of a core or on a dedicated responder port.
- Typical uses: preloading a core's private memory, and streaming words to the 0x1000_0000 LED register.

Parameters:
- LEN_W, 8: width of the word-count input and of the progress counter.
- TIMEOUT, 255: maximum cycles a request may wait for mem_ready. Used only when PICO_DMA_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; low 2 bits ignored (forced 0)
- dst_addr  in  32  destination byte address; low 2 bits ignored (forced 0)
- len_words  in  LEN_W  number of words to copy; 0 is legal
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- error  out  1  sticky until next accepted start; set on timeout
- words_done  out  LEN_W  number of words fully written so far
- mem_valid  out  1  request valid
- mem_ready  in  1  responder completion, one cycle per request
- mem_addr  out  32  word-aligned request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b0000 for reads, 4'b1111 for writes
- mem_rdata  in  32  read data; valid only in the mem_valid && mem_ready cycle

Behaviour:
- Reset: resetn low at a clk edge forces state IDLE and clears all outputs (busy, done, error, words_done, mem_valid, mem_addr, mem_wdata, mem_wstrb) plus internal counters.
- Reset during a transfer abandons it: no done pulse, and mem_valid is 0 from the next edge.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 latches src, dst and len into internal registers, clears error and words_done.
  - If len != 0, go to RD; if len = 0, go to FIN.
  - start is ignored in every other state.
- RD:
  - Outputs: mem_valid=1, mem_addr=src_ptr, mem_wstrb=0.
  - On mem_valid && mem_ready: capture mem_rdata into the data register, then go to WR.
- WR:
  - Outputs: mem_valid=1, mem_addr=dst_ptr, mem_wdata=data register, mem_wstrb=4'b1111.
  - On mem_ready:
    - src_ptr += 4 and dst_ptr += 4, with modulo-2^32 wrap.
    - words_done += 1 and remaining -= 1.
    - Go to RD if remaining becomes nonzero, otherwise FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Output timing: busy=1 in RD, WR and FIN. mem_valid is registered, and addr/wdata/wstrb are stable for the whole time mem_valid is high.
- Handshake:
  - A request completes only in a cycle where mem_valid && mem_ready.
  - The next request may assert in the immediately following cycle (back-to-back is legal).
  - mem_ready seen while mem_valid=0 is ignored.
- Latency:
  - Against a responder that raises ready one cycle after valid, each word costs 4 cycles.
  - Start accepted at edge N gives mem_valid at N+1. done pulses one cycle after the last write handshake.
  - len = 0: done one cycle after start, with no bus activity.
- Data path: no byte-lane or width conversion; full 32-bit words only.
- Capacity: maximum len is 2^LEN_W-1. words_done saturates naturally at len.
- A responder that never asserts ready stalls the block forever, unless PICO_DMA_TIMEOUT_EN is defined.

Optional Feature:
- Macro: PICO_DMA_TIMEOUT_EN.
- Defined:
  - A wait counter resets at each new request and increments every cycle mem_valid=1 without mem_ready.
  - When it reaches TIMEOUT: drop mem_valid on the next edge, set error=1, go to FIN (done still pulses). words_done reports the words completed before the abort.
- Undefined: no counter is built, error is tied to 0, and waits are unbounded.

Test Plan:
- Copy 3 words from 0x000 to 0x100, memory words 0..2 = 0x11111111, 0x22222222, 0x33333333, 1-cycle-ready responder -> bus sequence R0x000, W0x100, R0x004, W0x104, R0x008, W0x108; destination holds the same values; done at cycle 13 after start; words_done=3.
- len=0 start -> done pulse at cycle 1, mem_valid stays 0, busy high for exactly 1 cycle.
- Responder delays ready 5 cycles on the second read -> mem_valid, mem_addr=0x004 and mem_wstrb=0 stable for all 5 cycles; data correct.
- start pulsed while busy, with different src/dst -> ignored; the original transfer completes unchanged.
- Copy to dst 0x1000_0000 with src word 0x000000A5 -> write with mem_wstrb=4'hF and wdata 0x000000A5; the LED register reads 0xA5.
- With PICO_DMA_TIMEOUT_EN, TIMEOUT=10 and a responder that never readies -> mem_valid drops after 10 cycles, error=1, done pulses, words_done=0.
- resetn low mid-WR -> next cycle mem_valid=0, busy=0, no done pulse.
